sat_up_itl_ctrl: RTL
====================

# sat_up_itl_ctrl

Sequencing controller for the SAT_UP row/column interleaver buffer. It latches the link ID and derives the block length from it. It then steers serial input bits into a 256x1 buffer RAM and, on read requests, generates natural, interleaved and de-interleaved read addresses in lockstep. It sits between the serial bit source and the buffer RAM inside the SAT_UP interleaver top.

## Interface
- No parameters. Widths are fixed: 6-bit link ID, 8-bit addresses, 4 columns.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- link_id  in  6  link ID; sampled only on the accepted first bit of a block.
- din  in  1  serial data bit.
- din_vld  in  1  din qualifier, one bit per cycle.
- request  in  1  read strobe, one buffer read per high cycle.
- mem_wen  out  1  RAM write enable.
- mem_waddr  out  8  RAM write address.
- mem_wdata  out  1  RAM write data.
- mem_ren  out  1  RAM read enable; qualifies all three read addresses.
- mem_raddr_nat  out  8  natural-order read address.
- mem_raddr_itl  out  8  interleaved read address.
- mem_raddr_ditl  out  8  de-interleaved read address.
- dout_vld  out  1  RAM read data valid; mem_ren delayed one cycle.
- busy  out  1  high while in WRITE or READ.
- drop  out  1  one-cycle pulse when din_vld is ignored.

## Operation
- Geometry: R = link_id_latched + 1 rows (1..64), 4 columns, N = 4R bits (4..256).
- Data is written row-wise: bit j goes to address j.
- States: IDLE, WRITE, READ.
- IDLE:
  - din_vld=1 accepts bit 0, latches link_id, and moves to WRITE.
  - request is ignored.
- WRITE:
  - Each din_vld=1 cycle writes the next bit (write count w).
  - Acceptance of bit N-1 moves to READ.
  - request is ignored.
- READ:
  - Each request=1 cycle issues one read at index k (0..N-1).
  - Issue of k=N-1 returns to IDLE and clears the counters.
  - din_vld=1 in READ pulses drop; the bit is not written.
- The same-cycle din_vld that accepts bit N-1 and request together: only the write is performed; the request is ignored.
- Address generation is counter-based; no dividers or multipliers.
  - nat = k.
  - itl: row counter ri (0..R-1), column counter ci (0..3).
    - Address = {ri[5:0], ci[1:0]}.
    - ri increments each read; at R-1 it wraps to 0 and ci increments.
  - ditl: row counter dr = k>>2, column counter dc = k&3, base accumulator = dc*R.
    - Address = base + dr.
    - When dc increments, base += R.
    - When dc wraps 3->0, base <= 0 and dr increments.
- All address arithmetic is 8-bit unsigned. Maximum value is 3*64+63 = 255, so there is no overflow.
- Reset (asynchronous, any time including mid-block):
  - State goes to IDLE and all counters and the latched link ID go to 0.
  - mem_wen, mem_ren, dout_vld, busy and drop go to 0; all addresses and mem_wdata go to 0.
  - A partial block is discarded.

## Timing
- All outputs are registered.
- Write: din_vld/din sampled at edge t gives mem_wen=1, mem_waddr=w, mem_wdata=din in the cycle after t.
- Read: request sampled at edge t gives mem_ren=1 and all three addresses valid in the cycle after t. dout_vld=1 one cycle later (RAM read latency 1).
- Back-to-back din_vld or request produces back-to-back writes or reads at one per cycle. Gaps stall the counters.
- busy rises in the cycle after the first accepted bit. It falls in the cycle after the last read is issued; the final dout_vld still follows one cycle later.
- drop is high in the cycle after the ignored din_vld.
- A new block may start in the first IDLE cycle following the last read.

## Test plan
- Reset: hold n_rst=0, then release mid-clock.
  - Required: all outputs 0, busy=0.
  - Assert n_rst=0 during WRITE at w=10: outputs clear immediately; the next din_vld starts a fresh block at waddr 0.
- link_id=20 (R=21, N=84): 84 consecutive din_vld with alternating 1/0 data.
  - Required: mem_waddr 0..83, mem_wdata 1,0,1,...
  - State enters READ after bit 83.
- Same block, 84 request cycles.
  - itl sequence 0,4,8,...,80,1,5,...,83.
  - ditl sequence 0,21,42,63,1,22,43,64,2,...,83.
  - nat sequence 0..83.
  - dout_vld lags mem_ren by exactly 1 cycle; busy falls after the 84th read.
- Gapped requests in READ: pulses of 1, 2 and 5 cycles with idle gaps.
  - Exactly 8 reads occur, at k=0..7, with no skipped or repeated addresses.
- Boundaries:
  - link_id=0 (N=4): itl 0,1,2,3; ditl 0,1,2,3.
  - link_id=63 (N=256): final itl address 255, final ditl address 255, no wrap.
- Collisions:
  - din_vld during READ pulses drop with no write.
  - request during WRITE produces no read.
  - din_vld (bit N-1) together with request: write occurs, no read, READ entered next cycle.

Source files
------------

// File: rtl/sat_up_itl_ctrl.sv
// Sequencing controller for the SAT_UP 4-column row/column interleaver buffer.
// Writes a block of 4*(link_id+1) bits row-wise, then issues natural, interleaved and de-interleaved reads.
module sat_up_itl_ctrl (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [5:0] link_id,
    input  logic       din,
    input  logic       din_vld,
    input  logic       request,
    output logic       mem_wen,
    output logic [7:0] mem_waddr,
    output logic       mem_wdata,
    output logic       mem_ren,
    output logic [7:0] mem_raddr_nat,
    output logic [7:0] mem_raddr_itl,
    output logic [7:0] mem_raddr_ditl,
    output logic       dout_vld,
    output logic       busy,
    output logic       drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] link_r;
    logic [7:0] w_cnt;
    logic [7:0] k_cnt;
    logic [5:0] ri;
    logic [1:0] ci;
    logic [5:0] dr;
    logic [1:0] dc;
    logic [7:0] base;

    logic [7:0] rows;
    logic [7:0] last_idx;

    assign rows     = {2'b00, link_r} + 8'd1;
    assign last_idx = {link_r, 2'b11};

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            link_r         <= '0;
            w_cnt          <= '0;
            k_cnt          <= '0;
            ri             <= '0;
            ci             <= '0;
            dr             <= '0;
            dc             <= '0;
            base           <= '0;
            mem_wen        <= 1'b0;
            mem_waddr      <= '0;
            mem_wdata      <= 1'b0;
            mem_ren        <= 1'b0;
            mem_raddr_nat  <= '0;
            mem_raddr_itl  <= '0;
            mem_raddr_ditl <= '0;
            dout_vld       <= 1'b0;
            busy           <= 1'b0;
            drop           <= 1'b0;
        end else begin
            mem_wen  <= 1'b0;
            mem_ren  <= 1'b0;
            drop     <= 1'b0;
            dout_vld <= mem_ren;

            case (state)
                IDLE: begin
                    if (din_vld) begin
                        link_r    <= link_id;
                        mem_wen   <= 1'b1;
                        mem_waddr <= '0;
                        mem_wdata <= din;
                        w_cnt     <= 8'd1;
                        busy      <= 1'b1;
                        state     <= WRITE;
                    end
                end

                WRITE: begin
                    // A request coinciding with the final bit is deliberately dropped.
                    if (din_vld) begin
                        mem_wen   <= 1'b1;
                        mem_waddr <= w_cnt;
                        mem_wdata <= din;
                        if (w_cnt == last_idx) begin
                            w_cnt <= '0;
                            state <= READ;
                        end else begin
                            w_cnt <= w_cnt + 8'd1;
                        end
                    end
                end

                READ: begin
                    drop <= din_vld;
                    if (request) begin
                        mem_ren        <= 1'b1;
                        mem_raddr_nat  <= k_cnt;
                        mem_raddr_itl  <= {ri, ci};
                        mem_raddr_ditl <= base + {2'b00, dr};
                        if (k_cnt == last_idx) begin
                            k_cnt <= '0;
                            ri    <= '0;
                            ci    <= '0;
                            dr    <= '0;
                            dc    <= '0;
                            base  <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            k_cnt <= k_cnt + 8'd1;
                            if (ri == link_r) begin
                                ri <= '0;
                                ci <= ci + 2'd1;
                            end else begin
                                ri <= ri + 6'd1;
                            end
                            // base tracks dc*rows so the de-interleaved address needs only an add.
                            if (dc == 2'd3) begin
                                dc   <= '0;
                                base <= '0;
                                dr   <= dr + 6'd1;
                            end else begin
                                dc   <= dc + 2'd1;
                                base <= base + rows;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
